// File: rtl/mat_row_seq_if.sv
// Memory and row-datapath bus between mat_row_seq (master) and the matrix
// memory / combinational row unit (slave).
interface mat_row_seq_if #(
    parameter int unsigned ROW_W  = 40,
    parameter int unsigned ADDR_W = 4
);
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [ROW_W-1:0]  rd_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [ROW_W-1:0]  wr_data;
    logic              dp_rst;
    logic [ROW_W-1:0]  dp_row;
    logic [ROW_W-1:0]  dp_res;
    logic              dp_ovf;

    modport master (
        output rd_en, rd_addr, wr_en, wr_addr, wr_data, dp_rst, dp_row,
        input  rd_data, dp_res, dp_ovf
    );

    modport slave (
        input  rd_en, rd_addr, wr_en, wr_addr, wr_data, dp_rst, dp_row,
        output rd_data, dp_res, dp_ovf
    );
endinterface

// File: rtl/mat_row_seq.sv
// Row sequencer: streams N source rows through the row datapath and writes results back.
// Optional MAT_OVF_ABORT_EN: stop the command at the first overflowing row without writing it.
module mat_row_seq #(
    parameter int unsigned ROW_W    = 40,
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned MAX_ROWS = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [2:0]        size,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    mat_row_seq_if.master     bus,
    output logic              busy,
    output logic              done,
    output logic              ovf
);

    typedef enum logic [2:0] {StIdle, StRd, StCap, StExe, StWr, StDone} state_e;

    localparam logic [2:0] MaxRowsC = 3'(MAX_ROWS);

    state_e            state_q, state_d;
    logic [2:0]        size_q, size_d;
    logic [2:0]        r_q, r_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [ROW_W-1:0]  res_q, res_d;
    logic              ovf_q, ovf_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            size_q  <= '0;
            r_q     <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            row_q   <= '0;
            res_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            size_q  <= size_d;
            r_q     <= r_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            row_q   <= row_d;
            res_q   <= res_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        size_d      = size_q;
        r_d         = r_q;
        src_d       = src_q;
        dst_d       = dst_q;
        row_d       = row_q;
        res_d       = res_q;
        ovf_d       = ovf_q;
        bus.rd_en   = 1'b0;
        bus.rd_addr = '0;
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.dp_rst  = 1'b0;
        done        = 1'b0;

        unique case (state_q)
            StIdle: begin
                bus.dp_rst = 1'b1;
                if (start) begin
                    size_d  = (size > MaxRowsC) ? MaxRowsC : size;
                    src_d   = src_base;
                    dst_d   = dst_base;
                    r_d     = '0;
                    ovf_d   = 1'b0;
                    state_d = (size == 3'd0) ? StDone : StRd;
                end
            end
            StRd: begin
                bus.rd_en   = 1'b1;
                bus.rd_addr = src_q + ADDR_W'(r_q);
                state_d     = StCap;
            end
            StCap: begin
                row_d   = bus.rd_data;
                state_d = StExe;
            end
            StExe: begin
                res_d = bus.dp_res;
                ovf_d = ovf_q | bus.dp_ovf;
`ifdef MAT_OVF_ABORT_EN
                state_d = bus.dp_ovf ? StDone : StWr;
`else
                state_d = StWr;
`endif
            end
            StWr: begin
                bus.wr_en   = 1'b1;
                bus.wr_addr = dst_q + ADDR_W'(r_q);
                bus.wr_data = res_q;
                if (r_q == size_q - 3'd1) begin
                    state_d = StDone;
                end else begin
                    r_d     = r_q + 3'd1;
                    state_d = StRd;
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.dp_row = row_q;
    assign busy       = (state_q != StIdle);
    assign ovf        = ovf_q;

endmodule

// File: tb/tb_mat_row_seq.sv
// Directed bench for mat_row_seq with a negate-row datapath and a 16-row memory model.
// Expectations follow MAT_OVF_ABORT_EN when the macro is defined.
module tb_mat_row_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [2:0] size;
    logic [3:0] src_base;
    logic [3:0] dst_base;
    logic       busy;
    logic       done;
    logic       ovf;

    int n_cmp = 0;
    int n_bad = 0;

    logic [39:0] mem [16];

    mat_row_seq_if #(.ROW_W(40), .ADDR_W(4)) bus ();

    mat_row_seq #(.ROW_W(40), .ADDR_W(4), .MAX_ROWS(5)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .size     (size),
        .src_base (src_base),
        .dst_base (dst_base),
        .bus      (bus),
        .busy     (busy),
        .done     (done),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    function automatic logic [39:0] neg_row(input logic [39:0] x);
        logic [39:0] y;
        for (int i = 0; i < 5; i++) y[8*i +: 8] = 8'd0 - x[8*i +: 8];
        return y;
    endfunction

    function automatic logic row_ovf(input logic [39:0] x);
        logic o;
        o = 1'b0;
        for (int i = 0; i < 5; i++) if (x[8*i +: 8] == 8'h80) o = 1'b1;
        return o;
    endfunction

    function automatic logic [39:0] pat(input int a);
        return {8'(5*a+1), 8'(5*a+2), 8'(5*a+3), 8'(5*a+4), 8'(5*a+5)};
    endfunction

    // Negate-row datapath and 1-cycle read latency memory
    always_comb begin
        bus.dp_res = neg_row(bus.dp_row);
        bus.dp_ovf = row_ovf(bus.dp_row);
    end

    always @(posedge clk) if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic check_reset(input string p);
        chk({p, " rd_en"},   64'(bus.rd_en),   64'd0);
        chk({p, " wr_en"},   64'(bus.wr_en),   64'd0);
        chk({p, " done"},    64'(done),        64'd0);
        chk({p, " busy"},    64'(busy),        64'd0);
        chk({p, " ovf"},     64'(ovf),         64'd0);
        chk({p, " dp_row"},  64'(bus.dp_row),  64'd0);
        chk({p, " rd_addr"}, 64'(bus.rd_addr), 64'd0);
        chk({p, " wr_addr"}, 64'(bus.wr_addr), 64'd0);
        chk({p, " wr_data"}, 64'(bus.wr_data), 64'd0);
        chk({p, " dp_rst"},  64'(bus.dp_rst),  64'd1);
    endtask

    typedef struct {
        logic [2:0] size;
        logic [3:0] src;
        logic [3:0] dst;
        int         bad;    // row index holding 0x80, 7 = none
        int         ign;    // cycle to pulse an ignored start, 0 = none
        bit         pd;     // also pulse start in the done cycle
        int         e_nrd;
        int         e_nwr;
        int         e_done;
        bit         e_ovf;
    } vec_t;

    task automatic run_vec(input int id, input vec_t v);
        logic [39:0] gm [16];
        logic [39:0] ex_d [8];
        logic [3:0]  ex_a [8];
        logic [39:0] got_d [8];
        logic [3:0]  got_a [8];
        logic [39:0] row;
        int ex_n, n, k, nrd, nwr, done_cyc;
        bit bad_busy, bad_rda, bad_excl;
        string p;
        p = $sformatf("v%0d", id);

        for (int a = 0; a < 16; a++) mem[a] = pat(a);
        if (v.bad < 7) mem[4'(int'(v.src) + v.bad)][39:32] = 8'h80;
        for (int a = 0; a < 16; a++) gm[a] = mem[a];

        // Sequential reference: row r reads after all earlier rows wrote
        n    = (v.size > 3'd5) ? 5 : int'(v.size);
        ex_n = 0;
        for (int r = 0; r < n; r++) begin
            row = gm[4'(int'(v.src) + r)];
`ifdef MAT_OVF_ABORT_EN
            if (row_ovf(row)) break;
`endif
            ex_a[ex_n]     = 4'(int'(v.dst) + r);
            ex_d[ex_n]     = neg_row(row);
            gm[ex_a[ex_n]] = ex_d[ex_n];
            ex_n++;
        end

        size     = v.size;
        src_base = v.src;
        dst_base = v.dst;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        size     = 3'd1;
        src_base = ~v.src;
        dst_base = ~v.dst;

        k = 1; nrd = 0; nwr = 0; done_cyc = 0;
        bad_busy = 0; bad_rda = 0; bad_excl = 0;
        while (done_cyc == 0 && k <= 60) begin
            if (bus.rd_en && bus.wr_en) bad_excl = 1;
            if (!busy || bus.dp_rst) bad_busy = 1;
            if (bus.rd_en) begin
                if (bus.rd_addr !== 4'(int'(v.src) + nrd)) bad_rda = 1;
                nrd++;
            end
            if (bus.wr_en) begin
                if (nwr < 8) begin
                    got_a[nwr] = bus.wr_addr;
                    got_d[nwr] = bus.wr_data;
                end
                mem[bus.wr_addr] = bus.wr_data;
                nwr++;
            end
            if (done) begin
                done_cyc = k;
                if (v.pd) start = 1'b1;
            end
            if (k == v.ign) start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            k++;
        end

        chk({p, " done_cycle"}, 64'(done_cyc), 64'(v.e_done));
        chk({p, " reads"},      64'(nrd),      64'(v.e_nrd));
        chk({p, " writes"},     64'(nwr),      64'(v.e_nwr));
        chk({p, " ovf"},        64'(ovf),      64'(v.e_ovf));
        chk({p, " idle_after"}, 64'(busy),     64'd0);
        chk({p, " rd_addr_seq_err"}, 64'(bad_rda),  64'd0);
        chk({p, " busy_dprst_err"},  64'(bad_busy), 64'd0);
        chk({p, " rd_wr_overlap"},   64'(bad_excl), 64'd0);
        for (int i = 0; i < ex_n && i < nwr && i < 8; i++) begin
            chk($sformatf("%s wr%0d addr", p, i), 64'(got_a[i]), 64'(ex_a[i]));
            chk($sformatf("%s wr%0d data", p, i), 64'(got_d[i]), 64'(ex_d[i]));
        end
    endtask

    vec_t tbl [6];
    bit   strobe_err;

    initial begin
        tbl[0] = '{size: 3'd5, src: 4'd0,  dst: 4'd8,  bad: 7, ign: 0, pd: 0,
                   e_nrd: 5, e_nwr: 5, e_done: 21, e_ovf: 1'b0};
`ifdef MAT_OVF_ABORT_EN
        tbl[1] = '{size: 3'd5, src: 4'd0,  dst: 4'd8,  bad: 2, ign: 0, pd: 0,
                   e_nrd: 3, e_nwr: 2, e_done: 12, e_ovf: 1'b1};
`else
        tbl[1] = '{size: 3'd5, src: 4'd0,  dst: 4'd8,  bad: 2, ign: 0, pd: 0,
                   e_nrd: 5, e_nwr: 5, e_done: 21, e_ovf: 1'b1};
`endif
        tbl[2] = '{size: 3'd0, src: 4'd3,  dst: 4'd9,  bad: 7, ign: 0, pd: 0,
                   e_nrd: 0, e_nwr: 0, e_done: 1, e_ovf: 1'b0};
        tbl[3] = '{size: 3'd3, src: 4'd14, dst: 4'd15, bad: 7, ign: 0, pd: 0,
                   e_nrd: 3, e_nwr: 3, e_done: 13, e_ovf: 1'b0};
        tbl[4] = '{size: 3'd7, src: 4'd0,  dst: 4'd8,  bad: 7, ign: 6, pd: 1,
                   e_nrd: 5, e_nwr: 5, e_done: 21, e_ovf: 1'b0};
`ifdef MAT_OVF_ABORT_EN
        tbl[5] = '{size: 3'd1, src: 4'd5,  dst: 4'd5,  bad: 0, ign: 0, pd: 0,
                   e_nrd: 1, e_nwr: 0, e_done: 4, e_ovf: 1'b1};
`else
        tbl[5] = '{size: 3'd1, src: 4'd5,  dst: 4'd5,  bad: 0, ign: 0, pd: 0,
                   e_nrd: 1, e_nwr: 1, e_done: 5, e_ovf: 1'b1};
`endif

        rst_n    = 1'b0;
        start    = 1'b0;
        size     = 3'd0;
        src_base = 4'd0;
        dst_base = 4'd0;
        #12;
        check_reset("por");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++) run_vec(i, tbl[i]);

        // Reset in the middle of a command
        for (int a = 0; a < 16; a++) mem[a] = pat(a);
        size     = 3'd5;
        src_base = 4'd0;
        dst_base = 4'd8;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("midrst busy_before", 64'(busy), 64'd1);
        chk("midrst dp_row_before", 64'(bus.dp_row), 64'(pat(1)));
        rst_n = 1'b0;
        #1;
        check_reset("midrst");
        strobe_err = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (bus.rd_en || bus.wr_en || done || busy) strobe_err = 1;
        end
        chk("midrst activity_in_reset", 64'(strobe_err), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        strobe_err = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (bus.rd_en || bus.wr_en || done || busy) strobe_err = 1;
        end
        chk("midrst activity_after_release", 64'(strobe_err), 64'd0);
        run_vec(6, tbl[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mat_row_seq.md
# mat_row_seq

Row sequencer for the matrix coprocessor's per-row arithmetic datapath (five signed 8-bit elements packed into one 40-bit row). On a start command it streams the N rows of a source matrix from the matrix memory through the row datapath, writes each result row back to a destination region, and accumulates the datapath's overflow flag. It sits between the instruction decoder, the matrix memory and the combinational row units such as the negate-row unit.

## Interface
- `ROW_W`, 40: row width in bits (5 × int8).
- `ADDR_W`, 4: matrix memory address width.
- `MAX_ROWS`, 5: maximum matrix dimension.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  one-cycle command strobe; accepted only in IDLE.
- `size`  in  3  rows to process; sampled with `start`.
- `src_base`  in  ADDR_W  first source row address; sampled with `start`.
- `dst_base`  in  ADDR_W  first destination row address; sampled with `start`.
- `rd_en`  out  1  memory read strobe.
- `rd_addr`  out  ADDR_W  read address.
- `rd_data`  in  ROW_W  read data, valid exactly 1 cycle after `rd_en`.
- `dp_rst`  out  1  active-high clear to the row datapath.
- `dp_row`  out  ROW_W  registered operand row to the datapath.
- `dp_res`  in  ROW_W  combinational datapath result.
- `dp_ovf`  in  1  combinational datapath overflow.
- `wr_en`  out  1  memory write strobe.
- `wr_addr`  out  ADDR_W  write address.
- `wr_data`  out  ROW_W  write data.
- `busy`  out  1  high in any state except IDLE.
- `done`  out  1  one-cycle completion pulse.
- `ovf`  out  1  sticky overflow for the current or last command.

## Operation
- FSM states: IDLE, RD, CAP, EXE, WR, DONE.
- IDLE: `dp_rst`=1. On `start`, latch `size`, `src_base` and `dst_base`, clear `ovf` and the row counter `r`, then go to RD. If `size`=0, go directly to DONE. `size`>MAX_ROWS is clamped to MAX_ROWS.
- RD: `rd_en`=1, `rd_addr`=src_base+r (mod 2^ADDR_W). Go to CAP.
- CAP: `dp_row` ← `rd_data`. Go to EXE.
- EXE: latch `dp_res` into the result register. `ovf` ← `ovf` | `dp_ovf`. Go to WR.
- WR: `wr_en`=1, `wr_addr`=dst_base+r (mod 2^ADDR_W), `wr_data`=result register. If `r`=size−1, go to DONE; otherwise increment `r` and go to RD.
- DONE: `done`=1 for one cycle, then go to IDLE.
- `start` is ignored outside IDLE, including the DONE cycle.
- Changes on `size`, `src_base` or `dst_base` after the command is accepted have no effect on that command.
- `dp_rst`=0 in every state except IDLE.
- When the source and destination regions overlap, each row is read before it is written.

## Timing
- Reset (async, `rst_n`=0): FSM in IDLE. `rd_en`, `wr_en`, `done`, `busy` and `ovf` are 0. `dp_row`, `rd_addr`, `wr_addr` and `wr_data` are 0. `dp_rst`=1.
- Reset asserted mid-command aborts the command immediately. No further strobes are issued and no `done` pulse is produced.
- Each row takes 4 cycles (RD, CAP, EXE, WR).
- With `start` sampled at edge 0: RD of row 0 occupies cycle 1, and `done` is high in cycle 4N+1. `busy` is high in cycles 1..4N+1.
- For `size`=0, `done` is high in cycle 1.
- `ovf` is valid from the cycle after EXE and holds until the next accepted `start`.
- `rd_en` and `wr_en` are never high in the same cycle.

## Configuration
- `MAT_OVF_ABORT_EN`
  - Defined: if `dp_ovf`=1 in EXE, skip WR for that row and go straight to DONE. `ovf`=1, rows before it remain written, and no later rows are read or written.
  - Undefined: all N rows are always written, and `ovf` is purely sticky.

## Test plan
- Reset, then `start`, `size`=5, src=0, dst=8, negate datapath, rows 0x0102030405..: writes −row to addresses 8–12; `done` in cycle 21; `ovf`=0.
- Row 2 contains element 0x80: `ovf`=1 after row 2's EXE. Without the macro, 5 writes occur. With `MAT_OVF_ABORT_EN`, writes go to 8–9 only and `done` is in cycle 12.
- `size`=0: no `rd_en` or `wr_en`; `done` in cycle 1; `ovf` cleared.
- src=14, dst=15, `size`=3: reads 14, 15, 0; writes 15, 0, 1 (wrap-around); each row is read before the overlapping write.
- `start` pulsed in cycle 6 and in the DONE cycle: both ignored. `size`=7 is clamped to 5 rows.
- `rst_n` low in cycle 7: all outputs return to reset values at once; no `done` pulse; a subsequent `start` runs normally.
